fft_frame_loader: RTL and testbench

//   Upstream feeder for the 8-point FFT core. Accepts a serial stream of complex samples

---
 rtl/fft_pkg.sv | 20 ++
 rtl/fft_sample_bank.sv | 47 ++++
 rtl/fft_frame_loader.sv | 177 +++++++++++++++++
 tb/tb_fft_frame_loader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared constants and handoff FSM encoding for the FFT frame loader.
//   DATA_W_DEF  default sample component width
//   N_POINTS    samples per frame (FFT size)
//   IDX_W       width of a slot index within a frame
//   state_t     handoff FSM states
package fft_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int N_POINTS   = 8;
  localparam int IDX_W      = $clog2(N_POINTS);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_START = 3'd3,
    ST_WAIT  = 3'd4
  } state_t;

endpackage

// File: rtl/fft_sample_bank.sv
// fft_sample_bank: one frame buffer of N_POINTS complex samples {real, imag}.
//   clk, rst   clock, asynchronous active-low reset
//   wr_en      write wr_data into slot wr_idx
//   wr_idx     slot being written
//   wr_data    {real, imag} sample
//   wr_last    this write completes the frame: zero the slots above wr_idx, set full
//   clear      frame consumed, drop full
//   full       bank holds a complete frame
//   slots      bank contents, slot 0 first
module fft_sample_bank
  import fft_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                wr_en,
  input  logic [IDX_W-1:0]                    wr_idx,
  input  logic [2*DATA_W-1:0]                 wr_data,
  input  logic                                wr_last,
  input  logic                                clear,
  output logic                                full,
  output logic [N_POINTS-1:0][2*DATA_W-1:0]   slots
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full  <= 1'b0;
      slots <= '0;
    end else begin
      if (wr_en) begin
        for (int j = 0; j < N_POINTS; j++) begin
          if (j == int'(wr_idx))
            slots[j] <= wr_data;
          else if (wr_last && (j > int'(wr_idx)))
            slots[j] <= '0;
        end
        if (wr_last)
          full <= 1'b1;
      end
      // The top never clears the bank it is completing in the same cycle.
      if (clear)
        full <= 1'b0;
    end
  end

endmodule

// File: rtl/fft_frame_loader.sv
// fft_frame_loader: assembles a valid/ready sample stream into 8-sample frames in two
// ping-pong banks and hands each completed frame to the FFT core (write, start, wait done).
//   clk, rst                rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready       sample handshake
//   in_real, in_imag        signed sample, scaled by >>> IN_SHIFT on capture
//   in_last                 last sample of the frame
//   outN_real/outN_imag     frame sample N presented to the core, held until next load
//   write, start            one-cycle pulses to the core, start follows write
//   fft_done                core finished the current frame
//   busy                    handoff in progress
//   frame_err               one-cycle pulse: frame ended short, or ran to 8 without in_last
//
// state    | meaning
// ST_IDLE  | no frame at the core; a full bank is copied to out* on the exit edge
// ST_LOAD  | copy step; folded into the IDLE exit edge so write follows one edge
//          | after the completing accept; the encoding only falls through to WRITE
// ST_WRITE | write pulse, core latches out*
// ST_START | start pulse
// ST_WAIT  | core busy, waiting for fft_done
module fft_frame_loader
  import fft_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int IN_SHIFT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_real,
  input  logic [DATA_W-1:0] in_imag,
  input  logic              in_last,
  output logic [DATA_W-1:0] out0_real,
  output logic [DATA_W-1:0] out0_imag,
  output logic [DATA_W-1:0] out1_real,
  output logic [DATA_W-1:0] out1_imag,
  output logic [DATA_W-1:0] out2_real,
  output logic [DATA_W-1:0] out2_imag,
  output logic [DATA_W-1:0] out3_real,
  output logic [DATA_W-1:0] out3_imag,
  output logic [DATA_W-1:0] out4_real,
  output logic [DATA_W-1:0] out4_imag,
  output logic [DATA_W-1:0] out5_real,
  output logic [DATA_W-1:0] out5_imag,
  output logic [DATA_W-1:0] out6_real,
  output logic [DATA_W-1:0] out6_imag,
  output logic [DATA_W-1:0] out7_real,
  output logic [DATA_W-1:0] out7_imag,
  output logic              write,
  output logic              start,
  input  logic              fft_done,
  output logic              busy,
  output logic              frame_err
);

  logic                               fill_ptr;
  logic                               serve_ptr;
  logic [IDX_W-1:0]                   fill_idx;
  logic [1:0]                         bank_full;
  logic [N_POINTS-1:0][2*DATA_W-1:0]  bank_slots [2];
  logic [N_POINTS-1:0][2*DATA_W-1:0]  out_q;
  logic [DATA_W-1:0]                  cap_real;
  logic [DATA_W-1:0]                  cap_imag;
  logic                               accept;
  logic                               at_end;
  logic                               complete;
  logic                               load;
  state_t                             state;
  state_t                             state_nxt;

  assign cap_real = $signed(in_real) >>> IN_SHIFT;
  assign cap_imag = $signed(in_imag) >>> IN_SHIFT;

  assign in_ready = !bank_full[fill_ptr];
  assign accept   = in_valid & in_ready;
  assign at_end   = (fill_idx == IDX_W'(N_POINTS - 1));
  assign complete = accept & (at_end | in_last);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_sample_bank #(
      .DATA_W (DATA_W)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (accept & (fill_ptr == 1'(b))),
      .wr_idx  (fill_idx),
      .wr_data ({cap_real, cap_imag}),
      .wr_last (complete),
      .clear   (load & (serve_ptr == 1'(b))),
      .full    (bank_full[b]),
      .slots   (bank_slots[b])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_ptr  <= 1'b0;
      fill_idx  <= '0;
      frame_err <= 1'b0;
    end else begin
      // Short frame (in_last before slot 7) or overlong frame (no in_last at slot 7).
      frame_err <= accept & (at_end ^ in_last);
      if (accept) begin
        if (complete) begin
          fill_idx <= '0;
          fill_ptr <= ~fill_ptr;
        end else begin
          fill_idx <= fill_idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      serve_ptr <= 1'b0;
      out_q     <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        out_q     <= bank_slots[serve_ptr];
        serve_ptr <= ~serve_ptr;
      end
    end
  end

  // Banks fill strictly alternately and are served alternately, so the oldest
  // full bank is always the one serve_ptr names.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    write     = 1'b0;
    start     = 1'b0;
    busy      = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (bank_full[serve_ptr]) begin
          load      = 1'b1;
          state_nxt = ST_WRITE;
        end
      end
      ST_LOAD:  state_nxt = ST_WRITE;
      ST_WRITE: begin
        write     = 1'b1;
        state_nxt = ST_START;
      end
      ST_START: begin
        start     = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (fft_done)
          state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign out0_real = out_q[0][2*DATA_W-1:DATA_W];
  assign out0_imag = out_q[0][DATA_W-1:0];
  assign out1_real = out_q[1][2*DATA_W-1:DATA_W];
  assign out1_imag = out_q[1][DATA_W-1:0];
  assign out2_real = out_q[2][2*DATA_W-1:DATA_W];
  assign out2_imag = out_q[2][DATA_W-1:0];
  assign out3_real = out_q[3][2*DATA_W-1:DATA_W];
  assign out3_imag = out_q[3][DATA_W-1:0];
  assign out4_real = out_q[4][2*DATA_W-1:DATA_W];
  assign out4_imag = out_q[4][DATA_W-1:0];
  assign out5_real = out_q[5][2*DATA_W-1:DATA_W];
  assign out5_imag = out_q[5][DATA_W-1:0];
  assign out6_real = out_q[6][2*DATA_W-1:DATA_W];
  assign out6_imag = out_q[6][DATA_W-1:0];
  assign out7_real = out_q[7][2*DATA_W-1:DATA_W];
  assign out7_imag = out_q[7][DATA_W-1:0];

endmodule

// File: tb/tb_fft_frame_loader.sv
module tb_fft_frame_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [15:0] in_real = '0;
  logic [15:0] in_imag = '0;
  logic        fft_done = 1'b0;

  logic        in_ready, write, start, busy, frame_err;
  logic        r2, w2, st2, b2, fe2;
  logic [15:0] o_re [8];
  logic [15:0] o_im [8];
  logic [15:0] s_re [8];
  logic [15:0] s_im [8];
  logic [15:0] exp_s [8];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fft_frame_loader #(.DATA_W(16), .IN_SHIFT(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_real(in_real), .in_imag(in_imag), .in_last(in_last),
    .out0_real(o_re[0]), .out0_imag(o_im[0]), .out1_real(o_re[1]), .out1_imag(o_im[1]),
    .out2_real(o_re[2]), .out2_imag(o_im[2]), .out3_real(o_re[3]), .out3_imag(o_im[3]),
    .out4_real(o_re[4]), .out4_imag(o_im[4]), .out5_real(o_re[5]), .out5_imag(o_im[5]),
    .out6_real(o_re[6]), .out6_imag(o_im[6]), .out7_real(o_re[7]), .out7_imag(o_im[7]),
    .write(write), .start(start), .fft_done(fft_done), .busy(busy), .frame_err(frame_err)
  );

  fft_frame_loader #(.DATA_W(16), .IN_SHIFT(2)) dut_sh (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r2),
    .in_real(in_real), .in_imag(in_imag), .in_last(in_last),
    .out0_real(s_re[0]), .out0_imag(s_im[0]), .out1_real(s_re[1]), .out1_imag(s_im[1]),
    .out2_real(s_re[2]), .out2_imag(s_im[2]), .out3_real(s_re[3]), .out3_imag(s_im[3]),
    .out4_real(s_re[4]), .out4_imag(s_im[4]), .out5_real(s_re[5]), .out5_imag(s_im[5]),
    .out6_real(s_re[6]), .out6_imag(s_im[6]), .out7_real(s_re[7]), .out7_imag(s_im[7]),
    .write(w2), .start(st2), .fft_done(fft_done), .busy(b2), .frame_err(fe2)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0b want %0b", tag, obs, exp);
    end
  endtask

  // Drive one sample from a negedge; returns at the negedge after it was accepted.
  task automatic send(input logic [15:0] re, input logic [15:0] im, input logic last);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_real  = re;
    in_imag  = im;
    in_last  = last;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk1("send ready timeout", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_write(input string tag);
    int n;
    n = 0;
    while (write !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk1(tag, write, 1'b1);
  endtask

  task automatic pulse_done();
    fft_done = 1'b1;
    @(negedge clk);
    fft_done = 1'b0;
  endtask

  // From the WRITE negedge: step to WAIT, then complete the core's run.
  task automatic finish_frame();
    repeat (2) @(negedge clk);
    pulse_done();
  endtask

  initial begin
    // ---- reset state
    #2;
    chk1("rst write", write, 1'b0);
    chk1("rst start", start, 1'b0);
    chk1("rst busy", busy, 1'b0);
    chk1("rst frame_err", frame_err, 1'b0);
    chk("rst out0_real", o_re[0], 16'h0);
    chk("rst out7_imag", o_im[7], 16'h0);
    @(negedge clk);
    rst = 1'b1;
    chk1("rst in_ready", in_ready, 1'b1);

    // ---- done in IDLE is ignored
    pulse_done();
    chk1("idle done busy", busy, 1'b0);

    // ---- single frame 1..8 with exact handoff latency
    for (int i = 0; i < 8; i++) send(16'(i + 1), 16'h0, i == 7);
    chk1("t1 E0 write", write, 1'b0);
    chk1("t1 E0 busy", busy, 1'b0);
    chk1("t1 E0 frame_err", frame_err, 1'b0);
    @(negedge clk);
    chk1("t1 E1 write", write, 1'b1);
    chk1("t1 E1 start", start, 1'b0);
    chk1("t1 E1 busy", busy, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t1 out%0d_real", i), o_re[i], 16'(i + 1));
      chk($sformatf("t1 out%0d_imag", i), o_im[i], 16'h0);
      chk($sformatf("t1 sh out%0d_real", i), s_re[i], 16'((i + 1) >> 2));
    end
    fft_done = 1'b1;
    @(negedge clk);
    chk1("t1 E2 write", write, 1'b0);
    chk1("t1 E2 start", start, 1'b1);
    @(negedge clk);
    fft_done = 1'b0;
    chk1("t1 E3 start", start, 1'b0);
    repeat (3) @(negedge clk);
    chk1("t1 early done ignored", busy, 1'b1);
    pulse_done();
    chk1("t1 busy after done", busy, 1'b0);

    // ---- three back-to-back frames, done withheld
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 8; i++) send(16'(16'h100 * (f + 1) + i), 16'h0, i == 7);
    chk1("t2 ready low after 24", in_ready, 1'b0);
    chk("t2 A out0", o_re[0], 16'h100);
    chk("t2 A out7", o_re[7], 16'h107);
    repeat (20) @(negedge clk);
    chk1("t2 ready held low", in_ready, 1'b0);
    chk1("t2 busy held", busy, 1'b1);
    in_valid = 1'b1;
    in_real  = 16'h400;
    in_imag  = 16'h0;
    in_last  = 1'b0;
    fft_done = 1'b1;
    @(negedge clk);
    fft_done = 1'b0;
    chk1("t2 ready still low", in_ready, 1'b0);
    @(negedge clk);
    chk1("t2 B write", write, 1'b1);
    chk("t2 B out0", o_re[0], 16'h200);
    chk("t2 B out7", o_re[7], 16'h207);
    chk1("t2 ready after free", in_ready, 1'b1);
    for (int i = 0; i < 8; i++) send(16'(16'h400 + i), 16'h0, i == 7);
    pulse_done();
    wait_write("t2 C write");
    chk("t2 C out0", o_re[0], 16'h300);
    finish_frame();
    wait_write("t2 D write");
    chk("t2 D out0", o_re[0], 16'h400);
    chk("t2 D out7", o_re[7], 16'h407);
    finish_frame();
    chk1("t2 busy idle", busy, 1'b0);
    chk1("t2 ready idle", in_ready, 1'b1);

    // ---- short frame: in_last on the 5th sample, bank previously held frame C
    for (int i = 0; i < 5; i++) send(16'(i - 3), 16'h0, i == 4);
    chk1("t3 frame_err pulse", frame_err, 1'b1);
    exp_s = '{16'hFFFD, 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0, 16'h0, 16'h0};
    @(negedge clk);
    chk1("t3 frame_err once", frame_err, 1'b0);
    wait_write("t3 write");
    for (int i = 0; i < 8; i++) chk($sformatf("t3 out%0d_real", i), o_re[i], exp_s[i]);
    chk("t3 sh out0_real", s_re[0], 16'hFFFF);
    finish_frame();

    // ---- following frame: shift check, and overlong frame error at slot 7
    send(16'h8000, 16'h0007, 1'b0);
    send(16'h0007, 16'h8000, 1'b0);
    send(16'hFFFF, 16'h0000, 1'b0);
    for (int i = 3; i < 8; i++) send(16'(i + 2), 16'h0, 1'b0);
    chk1("t4 frame_err no last", frame_err, 1'b1);
    wait_write("t4 write");
    chk("t4 out0_real", o_re[0], 16'h8000);
    chk("t4 out1_imag", o_im[1], 16'h8000);
    chk("t4 out2_real", o_re[2], 16'hFFFF);
    chk("t4 sh out0_real", s_re[0], 16'hE000);
    chk("t4 sh out0_imag", s_im[0], 16'h0001);
    chk("t4 sh out1_real", s_re[1], 16'h0001);
    chk("t4 sh out1_imag", s_im[1], 16'hE000);
    chk("t4 sh out2_real", s_re[2], 16'hFFFF);
    finish_frame();

    // ---- reset during WRITE
    for (int i = 0; i < 8; i++) send(16'(16'h50 + i), 16'h0, i == 7);
    @(negedge clk);
    chk1("t5 pre-reset write", write, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk1("t5 rst write", write, 1'b0);
    chk1("t5 rst start", start, 1'b0);
    chk1("t5 rst busy", busy, 1'b0);
    chk("t5 rst out0", o_re[0], 16'h0);
    chk("t5 rst out7", o_re[7], 16'h0);
    @(negedge clk);
    rst = 1'b1;

    // ---- reset during fill at index 4
    for (int i = 0; i < 4; i++) send(16'(16'h60 + i), 16'h0, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk1("t6 rst ready", in_ready, 1'b1);
    chk1("t6 rst busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) send(16'(16'h70 + i), 16'h0, i == 7);
    chk1("t6 frame_err", frame_err, 1'b0);
    wait_write("t6 write");
    chk("t6 out0", o_re[0], 16'h70);
    chk("t6 out7", o_re[7], 16'h77);
    finish_frame();
    chk1("t6 busy idle", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
